vdp_cpu_vram_port: RTL

CPU-side VRAM/register port front end of the VDP, upstream of the VRAM access arbiter.
- Decodes CPU writes and reads on port 0 (VRAM data) and port 1 (address/register setup, two-byte sequence).
- Raises toggle-style requests to the arbiter: address set, CPU write, CPU read/prefetch.
- Captures read-back data into a one-byte read-ahead buffer.
- Emits register-write strobes toward the register file.

---
 rtl/vdp_cpu_vram_port.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vdp_cpu_vram_port.sv
// vdp_cpu_vram_port: CPU-side VRAM / register port front end of the VDP.
// Decodes port 0 (VRAM data) and port 1 (two-byte address/register setup)
// accesses, raises toggle requests toward the VRAM arbiter, keeps a one-byte
// read-ahead buffer and emits register-write strobes.
// Optional feature macro: CPU_VRAM_WAIT_EN (drives cpu_wait from pending requests).
module vdp_cpu_vram_port #(
    parameter int unsigned ADDR_HI_W = 5
) (
    input  logic                    CLK21M,
    input  logic                    RESET,
    input  logic [1:0]              DOTSTATE,
    input  logic                    cpu_wr,
    input  logic                    cpu_rd,
    input  logic                    cpu_port,
    input  logic [7:0]              cpu_dbo,
    input  logic [ADDR_HI_W-1:0]    REG_R14,
    input  logic [7:0]              PRAMDBI,
    input  logic                    VDPVRAMWRACK,
    input  logic                    VDPVRAMRDACK,
    input  logic                    VDPVRAMADDRSETACK,
    input  logic                    VDPVRAMREADINGR,
    output logic [7:0]              cpu_rd_data,
    output logic [7:0]              VDPVRAMACCESSDATA,
    output logic [ADDR_HI_W+13:0]   VDPVRAMACCESSADDRTMP,
    output logic                    VDPVRAMADDRSETREQ,
    output logic                    VDPVRAMWRREQ,
    output logic                    VDPVRAMRDREQ,
    output logic                    VDPVRAMREADINGA,
    output logic                    reg_wr_strobe,
    output logic [5:0]              reg_wr_num,
    output logic [7:0]              reg_wr_data,
    output logic                    cpu_wait
);

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_DATA_WR,
        ACC_CTRL_WR,
        ACC_DATA_RD,
        ACC_CTRL_RD
    } acc_e;

    acc_e        acc;
    logic        first_flag;
    logic [7:0]  first_byte;
    logic [7:0]  rdbuf;
    logic        wr_pending;
    logic        rd_pending;
    logic        as_pending;

    // A request is outstanding while our toggle differs from the arbiter's
    always_comb begin
        wr_pending = VDPVRAMWRREQ ^ VDPVRAMWRACK;
        rd_pending = VDPVRAMRDREQ ^ VDPVRAMRDACK;
        as_pending = VDPVRAMADDRSETREQ ^ VDPVRAMADDRSETACK;
    end

    // Classify the CPU access; a write wins over a simultaneous read
    always_comb begin
        acc = ACC_NONE;
        if (cpu_wr) begin
            acc = cpu_port ? ACC_CTRL_WR : ACC_DATA_WR;
        end else if (cpu_rd) begin
            acc = cpu_port ? ACC_CTRL_RD : ACC_DATA_RD;
        end
    end

    // CPU access handling: first-byte latch, request toggles, register strobes
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            first_flag           <= 1'b0;
            first_byte           <= '0;
            cpu_rd_data          <= '0;
            VDPVRAMACCESSDATA    <= '0;
            VDPVRAMACCESSADDRTMP <= '0;
            VDPVRAMADDRSETREQ    <= 1'b0;
            VDPVRAMWRREQ         <= 1'b0;
            VDPVRAMRDREQ         <= 1'b0;
            reg_wr_strobe        <= 1'b0;
            reg_wr_num           <= '0;
            reg_wr_data          <= '0;
        end else begin
            reg_wr_strobe <= 1'b0;
            unique case (acc)
                ACC_CTRL_WR: begin
                    if (!first_flag) begin
                        first_byte <= cpu_dbo;
                        first_flag <= 1'b1;
                    end else begin
                        first_flag <= 1'b0;
                        if (cpu_dbo[7]) begin
                            reg_wr_strobe <= 1'b1;
                            reg_wr_num    <= cpu_dbo[5:0];
                            reg_wr_data   <= first_byte;
                        end else begin
                            VDPVRAMACCESSADDRTMP <= {REG_R14, cpu_dbo[5:0], first_byte};
                            VDPVRAMADDRSETREQ    <= ~VDPVRAMADDRSETREQ;
                            // read setup starts a prefetch at the new address
                            if (!cpu_dbo[6]) begin
                                VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
                            end
                        end
                    end
                end
                ACC_DATA_WR: begin
                    // a still-pending write just has its data replaced
                    VDPVRAMACCESSDATA <= cpu_dbo;
                    if (!wr_pending) begin
                        VDPVRAMWRREQ <= ~VDPVRAMWRREQ;
                    end
                    first_flag <= 1'b0;
                end
                ACC_DATA_RD: begin
                    cpu_rd_data <= rdbuf;
                    if (!rd_pending) begin
                        VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
                    end
                    first_flag <= 1'b0;
                end
                ACC_CTRL_RD: begin
                    first_flag <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Capture VRAM read data into the read-ahead buffer during dot phase 01
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            rdbuf           <= '0;
            VDPVRAMREADINGA <= 1'b0;
        end else if ((VDPVRAMREADINGR != VDPVRAMREADINGA) && (DOTSTATE == 2'b01)) begin
            rdbuf           <= PRAMDBI;
            VDPVRAMREADINGA <= VDPVRAMREADINGR;
        end
    end

`ifdef CPU_VRAM_WAIT_EN
    // Hold the CPU while any request is still outstanding at the arbiter
    always_comb begin
        cpu_wait = wr_pending | rd_pending | as_pending;
    end
`else
    logic unused_as_pending;

    // Wait feature disabled: never stall the CPU
    always_comb begin
        cpu_wait          = 1'b0;
        unused_as_pending = as_pending;
    end
`endif

endmodule
